// File: rtl/sprite_plotter_pkg.sv
// ============================================================================
// Module : sprite_plotter_pkg
// Brief  : Shared screen geometry, colour defaults, FSM encoding and the
//          default sprite ROM image (checkerboard opacity mask).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_plotter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] DEF_FG_COLOUR = 3'b010;
  localparam logic [COLOUR_W-1:0] DEF_BG_COLOUR = 3'b000;

  // ROM image is sized for the largest supported sprite (16x16 words of 4 bits)
  localparam int ROM_BITS = 16 * 16 * 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word i = {opaque, rgb}: opaque on even (row+col), colour cycles 1..7
  function automatic logic [ROM_BITS-1:0] rom_checker(input int w, input int h);
    logic [ROM_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < w * h; i++) begin
      v[i*4 +: 4] = {(((i / w) + (i % w)) % 2) == 0, 3'((i % 7) + 1)};
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_rom.sv
// ============================================================================
// Module : sprite_rom
// Brief  : Sprite pixel store, 4-bit words {opaque, rgb}, one-cycle read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_rom
  import sprite_plotter_pkg::*;
#(
  parameter logic [ROM_BITS-1:0] INIT = '0
) (
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [3:0] q
);

  // Contents come from the INIT image so the store maps to ROM/LUTs with no loader
  always_ff @(posedge clk) begin
    q <= INIT[{addr, 2'b00} +: 4];
  end

endmodule

`default_nettype wire

// File: rtl/sprite_plotter.sv
// ============================================================================
// Module : sprite_plotter
// Brief  : Rasterises a SPR_W x SPR_H sprite, one VGA pixel write per clock,
//          with screen clipping; SPRITE_ROM_EN selects ROM-textured sprites.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_plotter
  import sprite_plotter_pkg::*;
#(
  parameter int                  SPR_W     = 4,
  parameter int                  SPR_H     = 4,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = DEF_FG_COLOUR,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = DEF_BG_COLOUR
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          x_pos,
  input  logic [5:0]          y_pos,
  input  logic                erase,
  output logic [7:0]          plot_x,
  output logic [6:0]          plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_en,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] COL_LAST = 4'(SPR_W - 1);
  localparam logic [3:0] ROW_LAST = 4'(SPR_H - 1);

  state_t state, state_next;

  logic [3:0]          col, row;
  logic [7:0]          x_lat;
  logic [5:0]          y_lat;
  logic                erase_lat;
  logic                col_last, row_last;
  logic [8:0]          x_sum;
  logic [6:0]          y_sum;
  logic                visible;
  logic                pix_opaque;
  logic [COLOUR_W-1:0] pix_colour;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign x_sum    = {1'b0, x_lat} + {5'd0, col};
  assign y_sum    = {1'b0, y_lat} + {3'd0, row};
  // Clipped pixels still consume their cycle so latency never depends on position
  assign visible  = (x_sum < 9'(SCREEN_W)) && (y_sum < 7'(SCREEN_H));

`ifdef SPRITE_ROM_EN
  localparam logic [7:0] SPR_W8 = 8'(SPR_W);

  logic [7:0] rom_addr;
  logic [3:0] rom_q;

  // Address the pixel that will be drawn on the next edge to hide the ROM latency
  always_comb begin
    rom_addr = '0;
    if (state == DRAW) begin
      if (col_last) rom_addr = ({4'd0, row} + 8'd1) * SPR_W8;
      else          rom_addr = {4'd0, row} * SPR_W8 + {4'd0, col} + 8'd1;
    end
  end

  sprite_rom #(
    .INIT(rom_checker(SPR_W, SPR_H))
  ) u_rom (
    .clk (CLOCK_50),
    .addr(rom_addr),
    .q   (rom_q)
  );

  assign pix_opaque = erase_lat | rom_q[3];
  assign pix_colour = erase_lat ? BG_COLOUR : rom_q[2:0];
`else
  assign pix_opaque = 1'b1;
  assign pix_colour = erase_lat ? BG_COLOUR : FG_COLOUR;
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRAW;
      DRAW:    if (col_last && row_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      col         <= '0;
      row         <= '0;
      x_lat       <= '0;
      y_lat       <= '0;
      erase_lat   <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      plot_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      plot_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_lat     <= x_pos;
            y_lat     <= y_pos;
            erase_lat <= erase;
            col       <= '0;
            row       <= '0;
          end
        end
        DRAW: begin
          plot_x      <= x_sum[7:0];
          plot_y      <= y_sum;
          plot_colour <= pix_colour;
          plot_en     <= visible & pix_opaque;
          busy        <= 1'b1;
          if (col_last) begin
            col <= '0;
            row <= row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
        DONE:    done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_plotter.sv
// ============================================================================
// Module : tb_sprite_plotter
// Brief  : Directed self-checking bench for sprite_plotter (4x4 sprite).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_plotter;

  logic       CLOCK_50;
  logic       resetn;
  logic       start;
  logic [7:0] x_pos;
  logic [5:0] y_pos;
  logic       erase;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot_en;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic       cap_en   [0:20];
  logic       cap_busy [0:20];
  logic       cap_done [0:20];
  logic [7:0] cap_x    [0:20];
  logic [6:0] cap_y    [0:20];
  logic [2:0] cap_c    [0:20];

  sprite_plotter dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (start),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .erase      (erase),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_colour(plot_colour),
    .plot_en    (plot_en),
    .busy       (busy),
    .done       (done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Cycle k is sampled at the negedge after edge N+k, N being the accepting edge.
  // After acceptance inputs are scrambled; rs/re >= 0 re-assert start with x=50,y=30.
  task automatic capture(input logic [7:0] x, input logic [5:0] y, input logic er,
                         input int rs, input int re);
    @(negedge CLOCK_50);
    start = 1'b1; x_pos = x; y_pos = y; erase = er;
    @(posedge CLOCK_50);
    for (int k = 0; k <= 20; k++) begin
      @(negedge CLOCK_50);
      cap_en[k] = plot_en; cap_busy[k] = busy; cap_done[k] = done;
      cap_x[k] = plot_x; cap_y[k] = plot_y; cap_c[k] = plot_colour;
      if (rs >= 0) begin
        start = (k >= rs && k <= re); x_pos = 8'd50; y_pos = 6'd30; erase = 1'b0;
      end else begin
        start = 1'b0; x_pos = 8'd77; y_pos = 6'd9; erase = ~er;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; x_pos = '0; y_pos = '0; erase = 1'b0;
    idle(3);
    checks++;
    if ({plot_x, plot_y, plot_colour, plot_en, busy, done} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%b en=%b busy=%b done=%b, want all 0",
               plot_x, plot_y, plot_colour, plot_en, busy, done);
    end
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_draw(input logic [7:0] x, input logic [5:0] y, input logic er,
                           input logic [2:0] col_exp, input string name);
    capture(x, y, er, -1, -1);
    for (int k = 0; k <= 18; k++) begin
      logic e_en, e_done;
      e_en = (k >= 1 && k <= 16);
      e_done = (k == 17);
      checks++;
      if ({cap_en[k], cap_busy[k], cap_done[k]} !== {e_en, e_en, e_done}) begin
        errors++;
        $display("FAIL %s_ctrl[%0d]: got en/busy/done=%b%b%b, want %b%b%b", name, k,
                 cap_en[k], cap_busy[k], cap_done[k], e_en, e_en, e_done);
      end
      if (e_en) begin
        checks++;
        if ({cap_x[k], cap_y[k], cap_c[k]} !==
            {8'(x + (k - 1) % 4), 7'(y + (k - 1) / 4), col_exp}) begin
          errors++;
          $display("FAIL %s_pix[%0d]: got (%0d,%0d) c=%b, want (%0d,%0d) c=%b", name, k,
                   cap_x[k], cap_y[k], cap_c[k], x + (k - 1) % 4, y + (k - 1) / 4, col_exp);
        end
      end
    end
    idle(3);
  endtask

  task automatic test_clip_right;
    int n;
    n = 0;
    capture(8'd158, 6'd5, 1'b0, -1, -1);
    for (int k = 1; k <= 17; k++) begin
      logic e_en;
      e_en = (k <= 16) && (((k - 1) % 4) < 2);
      if (cap_en[k]) n++;
      checks++;
      if (cap_en[k] !== e_en) begin
        errors++;
        $display("FAIL clip_en[%0d]: got %b, want %b", k, cap_en[k], e_en);
      end
      if (e_en) begin
        checks++;
        if ({cap_x[k], cap_y[k]} !== {8'(158 + (k - 1) % 4), 7'(5 + (k - 1) / 4)}) begin
          errors++;
          $display("FAIL clip_pix[%0d]: got (%0d,%0d), want (%0d,%0d)", k, cap_x[k],
                   cap_y[k], 158 + (k - 1) % 4, 5 + (k - 1) / 4);
        end
      end
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL clip_count: got %0d pixels, want 8", n);
    end
    checks++;
    if (cap_done[17] !== 1'b1) begin
      errors++;
      $display("FAIL clip_done: got done=%b at cycle 17, want 1", cap_done[17]);
    end
    idle(3);
  endtask

  task automatic test_back_to_back;
    capture(8'd10, 6'd20, 1'b0, 3, 17);
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if ({cap_en[k], cap_x[k], cap_y[k]} !==
          {1'b1, 8'(10 + (k - 1) % 4), 7'(20 + (k - 1) / 4)}) begin
        errors++;
        $display("FAIL b2b_pix[%0d]: got en=%b (%0d,%0d), want en=1 (%0d,%0d)", k,
                 cap_en[k], cap_x[k], cap_y[k], 10 + (k - 1) % 4, 20 + (k - 1) / 4);
      end
    end
    checks++;
    if ({cap_done[17], cap_en[18], cap_done[18]} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_done: got done17=%b en18=%b done18=%b, want 1 0 0",
               cap_done[17], cap_en[18], cap_done[18]);
    end
    checks++;
    if ({cap_en[19], cap_x[19], cap_y[19], cap_c[19]} !== {1'b1, 8'd50, 7'd30, 3'b010}) begin
      errors++;
      $display("FAIL b2b_restart: got en=%b (%0d,%0d) c=%b, want en=1 (50,30) c=010",
               cap_en[19], cap_x[19], cap_y[19], cap_c[19]);
    end
    idle(25);
  endtask

  task automatic test_reset_mid_draw;
    logic bad;
    @(negedge CLOCK_50);
    start = 1'b1; x_pos = 8'd10; y_pos = 6'd20; erase = 1'b0;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    repeat (7) @(posedge CLOCK_50);
    #2;
    checks++;
    if ({plot_en, plot_x, plot_y} !== {1'b1, 8'd12, 7'd21}) begin
      errors++;
      $display("FAIL mid_pixel7: got en=%b (%0d,%0d), want en=1 (12,21)", plot_en, plot_x, plot_y);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({plot_x, plot_y, plot_colour, plot_en, busy, done} !== 21'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got x=%0d y=%0d c=%b en=%b busy=%b done=%b, want all 0",
               plot_x, plot_y, plot_colour, plot_en, busy, done);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (done || plot_en || busy) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done: got activity after reset=%b, want 0", bad);
    end
  endtask

`ifdef SPRITE_ROM_EN
  task automatic test_rom;
    int n;
    n = 0;
    capture(8'd30, 6'd40, 1'b0, -1, -1);
    for (int k = 1; k <= 16; k++) begin
      logic e_en;
      int i;
      i = k - 1;
      e_en = (((i / 4) + (i % 4)) % 2) == 0;
      if (cap_en[k]) n++;
      checks++;
      if (cap_en[k] !== e_en || (e_en && cap_c[k] !== 3'((i % 7) + 1))) begin
        errors++;
        $display("FAIL rom_pix[%0d]: got en=%b c=%b, want en=%b c=%0d", k, cap_en[k],
                 cap_c[k], e_en, (i % 7) + 1);
      end
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL rom_count: got %0d pixels, want 8", n);
    end
    idle(3);
    test_draw(8'd30, 6'd40, 1'b1, 3'b000, "rom_erase");
  endtask
`endif

  initial begin
    test_reset();
`ifdef SPRITE_ROM_EN
    test_rom();
`else
    test_draw(8'd10, 6'd20, 1'b0, 3'b010, "solid");
    test_draw(8'd10, 6'd20, 1'b1, 3'b000, "erase");
    test_clip_right();
    test_draw(8'd20, 6'd63, 1'b0, 3'b010, "bottom");
    test_back_to_back();
    test_reset_mid_draw();
    test_draw(8'd0, 6'd0, 1'b0, 3'b010, "after_reset");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
